// File: rtl/tetris_input_pkg.sv
// Shared types for the move command scheduler.
//   cmd_t      : queued command code (ROTATE=up, DROP=down, LEFT, RIGHT)
//   ch_state_t : per-direction auto-repeat channel state
package tetris_input_pkg;

    typedef enum logic [1:0] {
        ROTATE = 2'd0,
        DROP   = 2'd1,
        LEFT   = 2'd2,
        RIGHT  = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_DELAY  = 2'd1,
        CH_REPEAT = 2'd2,
        CH_HELD   = 2'd3
    } ch_state_t;

    localparam int unsigned NUM_CH = 4;

endpackage

// File: rtl/move_cmd_scheduler_if.sv
// Command queue output bus.
//   cmd_valid  : queue head valid
//   cmd_code   : queue head command
//   cmd_ready  : consumer accepts head when cmd_valid && cmd_ready
//   overflow   : one-cycle pulse when an event is dropped on a full queue
//   fifo_count : current queue occupancy
interface move_cmd_scheduler_if
    import tetris_input_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          cmd_valid;
    cmd_t          cmd_code;
    logic          cmd_ready;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    modport master (output cmd_valid, cmd_code, overflow, fifo_count, input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_code, overflow, fifo_count, output cmd_ready);

endinterface

// File: rtl/dir_repeat_ch.sv
// One direction channel: edge sampling, DAS/ARR auto-repeat FSM and pending flag.
//   level   : debounced held input
//   freeze  : hold the counter and suppress repeat events (press events still fire)
//   clr     : arbiter consumed this channel's pending flag
//   pending : event waiting for arbitration
module dir_repeat_ch
    import tetris_input_pkg::*;
#(
    parameter int unsigned DAS_CYCLES = 20_000_000,
    parameter int unsigned ARR_CYCLES = 5_000_000,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic freeze,
    input  logic clr,
    output logic pending
);
    localparam int unsigned MAX_CYC = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample_q, sample_d;
    logic             pending_q, pending_d;
    logic             evt_c;

    // Sample register resets high so a button held through reset stays silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            sample_q  <= 1'b1;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            pending_q <= pending_d;
        end
    end

    // Next state, counter and event generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = level;
        evt_c    = 1'b0;
        if (!level) begin
            state_d = CH_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                CH_IDLE: begin
                    if (!sample_q) begin
                        evt_c   = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT_EN ? CH_DELAY : CH_HELD;
                    end
                end
                CH_DELAY: begin
                    if (!freeze) begin
                        if (cnt_q == DAS_LAST) begin
                            evt_c   = 1'b1;
                            cnt_d   = '0;
                            state_d = CH_REPEAT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                CH_REPEAT: begin
                    if (!freeze) begin
                        if (cnt_q == ARR_LAST) begin
                            evt_c = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                CH_HELD: begin
                    state_d = CH_HELD;
                end
                default: state_d = CH_IDLE;
            endcase
        end
        // A new event on an already-set flag merges; an event in the grant cycle survives the clear.
        pending_d = (pending_q & ~clr) | evt_c;
    end

    assign pending = pending_q;

endmodule

// File: rtl/move_cmd_scheduler.sv
// Turns four held direction inputs into a queue of move commands with DAS/ARR
// auto-repeat, fixed-priority arbitration and an overflow-reporting FIFO.
//   clk, rst_n            : clock, async active-low reset
//   up/down/left/right    : debounced held inputs
//   cmd_if (master)       : cmd_valid/cmd_code/cmd_ready/overflow/fifo_count
module move_cmd_scheduler
    import tetris_input_pkg::*;
#(
    parameter int unsigned DAS_CYCLES = 20_000_000,
    parameter int unsigned ARR_CYCLES = 5_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up,
    input  logic                  down,
    input  logic                  left,
    input  logic                  right,
    move_cmd_scheduler_if.master  cmd_if
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [NUM_CH-1:0] pend_c;
    logic [NUM_CH-1:0] grant_c;
    logic              freeze_lr_c;

    // Holding both left and right cancels their repeats.
    assign freeze_lr_c = left & right;

    dir_repeat_ch #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES), .REPEAT_EN(1'b0)) u_ch_rotate (
        .clk(clk), .rst_n(rst_n), .level(up), .freeze(1'b0),
        .clr(grant_c[ROTATE]), .pending(pend_c[ROTATE]));
    dir_repeat_ch #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES), .REPEAT_EN(1'b1)) u_ch_drop (
        .clk(clk), .rst_n(rst_n), .level(down), .freeze(1'b0),
        .clr(grant_c[DROP]), .pending(pend_c[DROP]));
    dir_repeat_ch #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES), .REPEAT_EN(1'b1)) u_ch_left (
        .clk(clk), .rst_n(rst_n), .level(left), .freeze(freeze_lr_c),
        .clr(grant_c[LEFT]), .pending(pend_c[LEFT]));
    dir_repeat_ch #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES), .REPEAT_EN(1'b1)) u_ch_right (
        .clk(clk), .rst_n(rst_n), .level(right), .freeze(freeze_lr_c),
        .clr(grant_c[RIGHT]), .pending(pend_c[RIGHT]));

    cmd_t          mem_q [FIFO_DEPTH];
    cmd_t          mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          cmd_valid_q, cmd_valid_d;
    cmd_t          cmd_code_q, cmd_code_d;
    logic          overflow_q, overflow_d;
    logic          push_c, pop_c, full_c, wr_en_c;
    cmd_t          push_code_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= ROTATE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= ROTATE;
            overflow_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            overflow_q  <= overflow_d;
        end
    end

    // Fixed-priority arbiter and FIFO update; head outputs are registered from next state.
    always_comb begin
        grant_c     = '0;
        push_c      = 1'b0;
        push_code_c = ROTATE;
        if (pend_c[ROTATE]) begin
            grant_c[ROTATE] = 1'b1; push_c = 1'b1; push_code_c = ROTATE;
        end else if (pend_c[DROP]) begin
            grant_c[DROP]   = 1'b1; push_c = 1'b1; push_code_c = DROP;
        end else if (pend_c[LEFT]) begin
            grant_c[LEFT]   = 1'b1; push_c = 1'b1; push_code_c = LEFT;
        end else if (pend_c[RIGHT]) begin
            grant_c[RIGHT]  = 1'b1; push_c = 1'b1; push_code_c = RIGHT;
        end

        full_c  = (count_q == CW'(FIFO_DEPTH));
        pop_c   = cmd_valid_q & cmd_if.cmd_ready;
        // When full, a same-cycle pop frees the head slot, which is also the tail slot.
        wr_en_c = push_c & (~full_c | pop_c);

        mem_d = mem_q;
        if (wr_en_c) mem_d[wr_ptr_q] = push_code_c;
        wr_ptr_d    = wr_ptr_q + PW'(wr_en_c);
        rd_ptr_d    = rd_ptr_q + PW'(pop_c);
        count_d     = count_q + CW'(wr_en_c) - CW'(pop_c);
        cmd_valid_d = (count_d != '0);
        cmd_code_d  = mem_d[rd_ptr_d];
        overflow_d  = push_c & full_c & ~pop_c;
    end

    assign cmd_if.cmd_valid  = cmd_valid_q;
    assign cmd_if.cmd_code   = cmd_code_q;
    assign cmd_if.overflow   = overflow_q;
    assign cmd_if.fifo_count = count_q;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Bench for move_cmd_scheduler with DAS=8, ARR=3, FIFO_DEPTH=4.
module tb_move_cmd_scheduler;
    import tetris_input_pkg::*;

    localparam int unsigned DAS   = 8;
    localparam int unsigned ARR   = 3;
    localparam int unsigned DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic cmd_ready = 1'b1;

    always #5 clk = ~clk;

    move_cmd_scheduler_if #(.FIFO_DEPTH(DEPTH)) cmd_if ();
    assign cmd_if.cmd_ready = cmd_ready;

    move_cmd_scheduler #(.DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .up(up), .down(down), .left(left), .right(right),
        .cmd_if(cmd_if));

    typedef struct {
        cmd_t code;
        int   cyc;   // -1: order-only check
    } exp_pop_t;

    typedef struct {
        logic u, d, l, r, rdy;
        int   exp_count;
        logic exp_ovf;
    } vec_t;

    exp_pop_t sb[$];
    vec_t     tbl[$];
    exp_pop_t mon_e;
    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted head is compared against the next expected command.
    always @(negedge clk) begin
        if (rst_n && cmd_if.cmd_valid && cmd_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got code %0d at cyc %0d, required no pop",
                         int'(cmd_if.cmd_code), cyc);
            end else begin
                mon_e = sb.pop_front();
                if (cmd_if.cmd_code != mon_e.code || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                    miscompares++;
                    $display("FAIL pop: got code %0d at cyc %0d, required code %0d at cyc %0d",
                             int'(cmd_if.cmd_code), cyc, int'(mon_e.code), mon_e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pop(input cmd_t code, input int at);
        exp_pop_t e;
        e.code = code;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    function automatic vec_t mkv(input logic u, d, l, r, rdy, input int cnt, input logic ovf);
        vec_t v;
        v.u = u; v.d = d; v.l = l; v.r = r; v.rdy = rdy;
        v.exp_count = cnt; v.exp_ovf = ovf;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int waited;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_cmd_valid",  int'(cmd_if.cmd_valid), 0);
        check("rst_fifo_count", int'(cmd_if.fifo_count), 0);
        check("rst_overflow",   int'(cmd_if.overflow), 0);
        check("rst_cmd_code",   int'(cmd_if.cmd_code), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // Hold left 20 cycles: press, press+8, then every 3 cycles; nothing after release
        c = cyc;
        expect_pop(LEFT, c + 2);
        expect_pop(LEFT, c + 10);
        expect_pop(LEFT, c + 13);
        expect_pop(LEFT, c + 16);
        expect_pop(LEFT, c + 19);
        left = 1'b1;
        tick(20);
        left = 1'b0;
        tick(15);
        check("left_hold_all_popped", sb.size(), 0);

        // Simultaneous up/down/right: priority order on consecutive cycles
        c = cyc;
        expect_pop(ROTATE, c + 2);
        expect_pop(DROP,   c + 3);
        expect_pop(RIGHT,  c + 4);
        up = 1'b1; down = 1'b1; right = 1'b1;
        tick(3);
        up = 1'b0; down = 1'b0; right = 1'b0;
        tick(8);
        check("simul_all_popped", sb.size(), 0);

        // Table: fill/overflow/drain, then full-queue push with same-cycle pop
        tbl.push_back(mkv(1,0,0,0,0, 0,0));
        tbl.push_back(mkv(0,0,0,0,0, 1,0));
        tbl.push_back(mkv(0,1,0,0,0, 1,0));
        tbl.push_back(mkv(0,0,0,0,0, 2,0));
        tbl.push_back(mkv(0,0,1,0,0, 2,0));
        tbl.push_back(mkv(0,0,0,0,0, 3,0));
        tbl.push_back(mkv(0,0,0,1,0, 3,0));
        tbl.push_back(mkv(0,0,0,0,0, 4,0));
        tbl.push_back(mkv(1,0,0,0,0, 4,0));
        tbl.push_back(mkv(0,0,0,0,0, 4,1));
        tbl.push_back(mkv(0,1,0,0,0, 4,0));
        tbl.push_back(mkv(0,0,0,0,0, 4,1));
        tbl.push_back(mkv(0,0,0,0,0, 4,0));
        tbl.push_back(mkv(0,0,0,0,1, 3,0));
        tbl.push_back(mkv(0,0,0,0,1, 2,0));
        tbl.push_back(mkv(0,0,0,0,1, 1,0));
        tbl.push_back(mkv(0,0,0,0,1, 0,0));
        tbl.push_back(mkv(0,0,0,0,1, 0,0));
        tbl.push_back(mkv(1,0,0,0,0, 0,0));
        tbl.push_back(mkv(0,1,0,0,0, 1,0));
        tbl.push_back(mkv(0,0,1,0,0, 2,0));
        tbl.push_back(mkv(0,0,0,1,0, 3,0));
        tbl.push_back(mkv(1,0,0,0,0, 4,0));
        tbl.push_back(mkv(0,0,0,0,1, 4,0));
        tbl.push_back(mkv(0,0,0,0,0, 4,0));
        tbl.push_back(mkv(0,0,0,0,1, 3,0));
        tbl.push_back(mkv(0,0,0,0,1, 2,0));
        tbl.push_back(mkv(0,0,0,0,1, 1,0));
        tbl.push_back(mkv(0,0,0,0,1, 0,0));
        expect_pop(ROTATE, -1);
        expect_pop(DROP,   -1);
        expect_pop(LEFT,   -1);
        expect_pop(RIGHT,  -1);
        expect_pop(ROTATE, -1);
        expect_pop(DROP,   -1);
        expect_pop(LEFT,   -1);
        expect_pop(RIGHT,  -1);
        expect_pop(ROTATE, -1);
        for (int i = 0; i < tbl.size(); i++) begin
            up = tbl[i].u; down = tbl[i].d; left = tbl[i].l; right = tbl[i].r;
            cmd_ready = tbl[i].rdy;
            tick(1);
            check($sformatf("row%0d_count", i), int'(cmd_if.fifo_count), tbl[i].exp_count);
            check($sformatf("row%0d_valid", i), int'(cmd_if.cmd_valid), (tbl[i].exp_count != 0) ? 1 : 0);
            check($sformatf("row%0d_overflow", i), int'(cmd_if.overflow), int'(tbl[i].exp_ovf));
        end
        cmd_ready = 1'b1;
        tick(3);
        check("table_all_popped", sb.size(), 0);

        // Left and right held together: one press event each, no repeats
        c = cyc;
        expect_pop(LEFT,  c + 2);
        expect_pop(RIGHT, c + 3);
        left = 1'b1; right = 1'b1;
        tick(30);
        left = 1'b0; right = 1'b0;
        tick(10);
        check("lr_all_popped", sb.size(), 0);

        // Reset while down repeats with two entries queued
        c = cyc;
        expect_pop(DROP, c + 2);
        expect_pop(DROP, c + 10);
        down = 1'b1;
        tick(11);
        cmd_ready = 1'b0;
        waited = 0;
        while (cmd_if.fifo_count != 2 && waited < 20) begin
            tick(1);
            waited++;
        end
        check("pre_reset_count", int'(cmd_if.fifo_count), 2);
        check("pre_reset_popped", sb.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cmd_valid",  int'(cmd_if.cmd_valid), 0);
        check("midrst_fifo_count", int'(cmd_if.fifo_count), 0);
        check("midrst_overflow",   int'(cmd_if.overflow), 0);
        tick(2);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        tick(20);
        check("post_reset_held_count", int'(cmd_if.fifo_count), 0);
        down = 1'b0;
        tick(2);
        c = cyc;
        expect_pop(DROP, c + 2);
        down = 1'b1;
        tick(3);
        down = 1'b0;
        tick(5);
        check("repress_all_popped", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/move_cmd_scheduler.md
MOVE_CMD_SCHEDULER -- requirements
Module: move_cmd_scheduler

Interface
REQ-001 Parameter DAS_CYCLES, default 20_000_000, is the hold time before auto-repeat starts (200 ms at 100 MHz).
REQ-002 Parameter ARR_CYCLES, default 5_000_000, is the auto-repeat period once repeating.
REQ-003 Parameter FIFO_DEPTH, default 4, is the command queue depth (power of two, >=2).
REQ-004 clk  in  1  single system clock; every register is clocked on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 up, down, left, right  in  1 each  debounced, level-high "held" inputs.
REQ-007 cmd_valid  out  1  queue head is valid.
REQ-008 cmd_code  out  2  head command: ROTATE=0 (up), DROP=1 (down), LEFT=2, RIGHT=3.
REQ-009 cmd_ready  in  1  consumer accepts head when cmd_valid && cmd_ready.
REQ-010 overflow  out  1  one-cycle pulse when an event is dropped on a full queue.
REQ-011 fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-012 Each direction has its own channel: input sampling register, FSM, counter (width $clog2(max(DAS_CYCLES,ARR_CYCLES))+1) and pending flag.
REQ-013 DROP/LEFT/RIGHT FSM states: IDLE, DELAY, REPEAT; ROTATE FSM states: IDLE, HELD (no auto-repeat).
REQ-014 IDLE -> DELAY (or HELD) on rising edge (level=1, previous sample=0); an event is raised and the counter is cleared.
REQ-015 In DELAY the counter increments each cycle; at count DAS_CYCLES-1 an event is raised, the counter clears and the FSM goes to REPEAT.
REQ-016 In REPEAT an event is raised every ARR_CYCLES cycles.
REQ-017 Level=0 in any state -> IDLE next cycle, counter cleared, and no event is raised.
REQ-018 While left and right are both high, the LEFT and RIGHT counters freeze and raise no repeat events; their initial press events are still raised.
REQ-019 A raised event sets the channel pending flag at that clock edge.
REQ-020 Each cycle the arbiter selects at most one pending flag and clears it.
  - Fixed priority: ROTATE > DROP > LEFT > RIGHT.
  - Losing flags stay set.
REQ-021 A new event on a channel whose flag is already set merges into that flag; it is not counted twice.
REQ-022 Push of a selected event:
  - Queue not full, or a pop occurs in the same cycle: the event is written at the tail.
  - Otherwise: the event is discarded and overflow pulses for one cycle.
REQ-023 Latency: input rising before edge k sets pending at edge k; if it wins arbitration and the queue is empty, cmd_valid=1 after edge k+1.
REQ-024 cmd_valid = (fifo_count != 0); cmd_code and cmd_valid stay stable while cmd_valid && !cmd_ready.
REQ-025 Simultaneous push and pop leaves fifo_count unchanged, including when the queue is full or holds exactly one entry.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH or underflows.

Reset
REQ-027 While rst_n=0 (asynchronous):
  - FSMs=IDLE, counters=0, pending=0, pointers=0.
  - fifo_count=0, cmd_valid=0, overflow=0, cmd_code=0.
REQ-028 Input sampling registers reset to 1, so a button held through reset release raises no event until it is released and pressed again.
REQ-029 Reset asserted mid-repeat or with a non-empty queue discards all state immediately.

Structure
REQ-030 Shared package tetris_input_pkg holds the cmd_t enum (ROTATE, DROP, LEFT, RIGHT) and the channel FSM state enum.
REQ-031 One sub-module, dir_repeat_ch, holds the sampling register, FSM, counter and pending flag.
  - It is instantiated four times; the ROTATE instance has repeat disabled via a parameter.
  - The FIFO and arbiter stay in the top module.

Verification (bench parameters: DAS_CYCLES=8, ARR_CYCLES=3, FIFO_DEPTH=4, cmd_ready=1 unless stated)
REQ-032 Hold left for 20 cycles:
  - One LEFT push at press, one at press+8, then one every 3 cycles.
  - Release -> no further LEFT pushes.
REQ-033 up, down and right all rise in the same cycle: queue receives ROTATE, DROP, RIGHT on three consecutive cycles.
REQ-034 cmd_ready=0, then 6 distinct presses: fifo_count saturates at 4 and overflow pulses on the 5th and 6th pushes. cmd_ready=1 then drains in order ROTATE/DROP/LEFT/RIGHT as pressed.
REQ-035 Full queue, cmd_ready=1 while a new push arrives in the same cycle: fifo_count stays 4 and no overflow occurs.
REQ-036 Left and right both held for 30 cycles: exactly one LEFT and one RIGHT push total.
REQ-037 Reset pulse while down is repeating and 2 entries are queued:
  - cmd_valid=0 immediately.
  - With down still held after rst_n rises, no DROP push occurs until down is released and pressed again.
